// File: rtl/simon_block_feeder.sv
// Word-pair packer and block FIFO feeding the SIMON 128/128 core handshake.
// Optional statistics (blocksIssued, dropWord) are enabled with `define SIMON_FEEDER_STATS_EN.
module simon_block_feeder #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         nR,
  input  logic                         flush,
  input  logic [N-1:0]                 inWord,
  input  logic                         inValid,
  output logic                         inReady,
  output logic [1:0][N-1:0]            BLOCK,
  output logic                         newData,
  input  logic                         loadData,
  input  logic                         doneData,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef SIMON_FEEDER_STATS_EN
  ,
  output logic [31:0]                  blocksIssued,
  output logic                         dropWord
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_DONE} state_t;

  state_t              state, next_state;
  logic [1:0][N-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       count;
  logic [N-1:0]        half_word;
  logic                half_valid;
  logic                done_q;
  logic                accept, push, pop, done_rise;

  assign empty     = (count == '0);
  assign full      = (count == LW'(DEPTH));
  assign level     = count;
  assign inReady   = !full && !flush;
  assign newData   = (state == PRESENT);
  assign accept    = inValid && inReady;
  assign push      = accept && half_valid;
  // Popping the head coincides with latching it into BLOCK, so the block on
  // the core bus is no longer counted in level.
  assign pop       = (state == IDLE) && !empty && !flush;
  assign done_rise = doneData && !done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state is defaulted first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (!empty)   next_state = PRESENT;
      PRESENT:   if (loadData) next_state = WAIT_DONE;
      WAIT_DONE: if (done_rise) next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      half_word  <= '0;
      half_valid <= 1'b0;
      done_q     <= 1'b0;
      BLOCK      <= '0;
    end else begin
      done_q <= doneData;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        half_valid <= 1'b0;
      end else begin
        if (accept) begin
          half_valid <= !half_valid;
          if (!half_valid) half_word <= inWord;
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          BLOCK  <= mem[rd_ptr];
        end
        if (push && !pop)      count <= count + LW'(1);
        else if (pop && !push) count <= count - LW'(1);
      end
    end
  end

  // NOTE: storage is deliberately left out of reset; count and pointers alone
  // define which entries are valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {half_word, inWord};
  end

`ifdef SIMON_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      blocksIssued <= '0;
    end else if (flush) begin
      blocksIssued <= '0;
    end else if (state == PRESENT && loadData) begin
      blocksIssued <= blocksIssued + 32'd1;
    end
  end

  assign dropWord = inValid && full;
`endif

endmodule

// File: tb/tb_simon_block_feeder.sv
// Directed bench for simon_block_feeder: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_simon_block_feeder;

  logic               clk = 1'b0;
  logic               nR = 1'b0;
  logic               flush = 1'b0;
  logic [63:0]        inWord = '0;
  logic               inValid = 1'b0;
  logic               inReady;
  logic [1:0][63:0]   BLOCK;
  logic               newData;
  logic               loadData = 1'b0;
  logic               doneData = 1'b0;
  logic               empty, full;
  logic [2:0]         level;
`ifdef SIMON_FEEDER_STATS_EN
  logic [31:0]        blocksIssued;
  logic               dropWord;
`endif

  simon_block_feeder #(.N(64), .DEPTH(4)) dut (
    .clk(clk), .nR(nR), .flush(flush),
    .inWord(inWord), .inValid(inValid), .inReady(inReady),
    .BLOCK(BLOCK), .newData(newData),
    .loadData(loadData), .doneData(doneData),
    .empty(empty), .full(full), .level(level)
`ifdef SIMON_FEEDER_STATS_EN
    , .blocksIssued(blocksIssued), .dropWord(dropWord)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a queue of complete blocks waiting for the core, the
  // pending upper half, and what the core bus currently shows.
  logic [127:0] m_q [$];
  logic [63:0]  m_half;
  bit           m_half_v, m_pres, m_wait, m_done_prev, m_was_full, m_rise;
  logic [127:0] m_blk;
  int unsigned  m_issued;

  always @(posedge clk or negedge nR) begin
    if (!nR) begin
      m_q.delete();
      m_half_v = 0; m_pres = 0; m_wait = 0; m_done_prev = 0;
      m_blk = '0; m_half = '0; m_issued = 0;
    end else begin
      m_was_full  = (m_q.size() == 4);
      m_rise      = doneData && !m_done_prev;
      m_done_prev = doneData;
      if (flush) begin
        m_q.delete();
        m_half_v = 0; m_pres = 0; m_wait = 0; m_issued = 0;
      end else begin
        if (m_pres) begin
          if (loadData) begin m_pres = 0; m_wait = 1; m_issued++; end
        end else if (m_wait) begin
          if (m_rise) m_wait = 0;
        end else if (m_q.size() > 0) begin
          m_blk  = m_q.pop_front();
          m_pres = 1;
        end
        if (inValid && !m_was_full) begin
          if (m_half_v) begin m_q.push_back({m_half, inWord}); m_half_v = 0; end
          else begin m_half = inWord; m_half_v = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc inReady", inReady, (m_q.size() != 4) && !flush);
    check("cyc empty",   empty,   m_q.size() == 0);
    check("cyc full",    full,    m_q.size() == 4);
    check("cyc level",   level,   m_q.size());
    check("cyc newData", newData, m_pres);
    check("cyc BLOCK",   BLOCK,   m_blk);
`ifdef SIMON_FEEDER_STATS_EN
    check("cyc blocksIssued", blocksIssued, m_issued);
    check("cyc dropWord",     dropWord,     inValid && (m_q.size() == 4));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [127:0] b);
    inValid = 1'b1; inWord = b[127:64]; tick();
    inWord  = b[63:0];                  tick();
    inValid = 1'b0;
  endtask

  task automatic finish_block();
    doneData = 1'b1; tick();
    doneData = 1'b0;
  endtask

  task automatic take_block(input string name, input logic [127:0] exp);
    for (int k = 0; k < 8 && !newData; k++) tick();
    check({name, " newData"}, newData, 1);
    check(name, BLOCK, exp);
    loadData = 1'b1; tick();
    loadData = 1'b0;
  endtask

  logic [127:0] blk_a, bt [5], c0, c1, c2, f_blk, g_blk, h_blk;

  initial begin
    blk_a = 128'h63736564207372656C6C657661727420;
    bt[0] = 128'hA8D5F7DE0123FEDC01234567FEDCBA98;
    bt[1] = 128'h11111111222222223333333344444444;
    bt[2] = 128'h55555555666666667777777788888888;
    bt[3] = 128'h99999999AAAAAAAABBBBBBBBCCCCCCCC;
    bt[4] = 128'hDDDDDDDDEEEEEEEEFFFFFFFF00000000;
    c0    = 128'hC0000000000000010000000000000002;
    c1    = 128'hC1000000000000030000000000000004;
    c2    = 128'hC2000000000000050000000000000006;
    f_blk = 128'hF1F1F1F1F1F1F1F1F2F2F2F2F2F2F2F2;
    g_blk = 128'h0123456789ABCDEF0FEDCBA987654321;
    h_blk = 128'h4848484848484848A5A5A5A5A5A5A5A5;

    repeat (2) @(posedge clk);
    #1 nR = 1'b1;
    check("reset inReady", inReady, 1);
    check("reset empty",   empty,   1);
    check("reset level",   level,   0);
    check("reset newData", newData, 0);

    // First block: presented one cycle after its push.
    send_pair(blk_a);
    tick();
    check("present newData", newData, 1);
    check("present BLOCK",   BLOCK,   blk_a);
    check("present level",   level,   0);

    repeat (10) tick();
    check("hold newData", newData, 1);
    check("hold BLOCK",   BLOCK,   blk_a);
    loadData = 1'b1; tick(); loadData = 1'b0;
    check("load newData", newData, 0);

    // Core busy: fill the FIFO, then stall a fifth pair.
    for (int i = 0; i < 4; i++) send_pair(bt[i]);
    check("fill full",    full,    1);
    check("fill inReady", inReady, 0);
    check("fill level",   level,   4);
    check("no re-present", newData, 0);
    inValid = 1'b1; inWord = bt[4][127:64];
    repeat (3) tick();
    check("stall level", level, 4);
    inValid = 1'b0;
    finish_block();
    tick();
    check("after present level", level, 3);
    send_pair(bt[4]);
    check("refill level", level, 4);
    take_block("wrap blk0", bt[0]);
    for (int i = 1; i < 5; i++) begin
      finish_block();
      take_block($sformatf("wrap blk%0d", i), bt[i]);
    end

    // Push coinciding with pop at level 2.
    send_pair(c0);
    send_pair(c1);
    check("pp level before", level, 2);
    inValid = 1'b1; inWord = c2[127:64]; doneData = 1'b1; tick();
    doneData = 1'b0; inWord = c2[63:0]; tick();
    inValid = 1'b0;
    check("pp level after", level, 2);
    check("pp BLOCK", BLOCK, c0);
    loadData = 1'b1; tick(); loadData = 1'b0;
    finish_block();
    take_block("pp c1", c1);
    finish_block();
    take_block("pp c2", c2);
    finish_block();

    // Flush discards a pending half word.
    inValid = 1'b1; inWord = 64'hDEADDEADDEADDEAD; tick();
    inWord = 64'hBADBADBADBADBAD0; flush = 1'b1;
    #1 check("flush inReady", inReady, 0);
    tick();
    flush = 1'b0; inValid = 1'b0;
    send_pair(f_blk);
    take_block("flush pair", f_blk);
    finish_block();

    // Asynchronous reset in WAIT_DONE with three blocks queued and a half word.
    send_pair(g_blk);
    tick();
    loadData = 1'b1; tick(); loadData = 1'b0;
    send_pair(c0); send_pair(c1); send_pair(c2);
    inValid = 1'b1; inWord = 64'h7777777777777777; tick();
    inValid = 1'b0;
    check("pre-reset level", level, 3);
    #2 nR = 1'b0;
    #1;
    check("arst newData", newData, 0);
    check("arst level",   level,   0);
    check("arst empty",   empty,   1);
    check("arst full",    full,    0);
    check("arst inReady", inReady, 1);
    check("arst BLOCK",   BLOCK,   128'h0);
`ifdef SIMON_FEEDER_STATS_EN
    check("arst blocksIssued", blocksIssued, 0);
`endif
    @(posedge clk); #1 nR = 1'b1;
    send_pair(h_blk);
    take_block("post-reset pair", h_blk);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
